ysyx_24080014_mem_arbiter: RTL
==============================

# ysyx_24080014_mem_arbiter

Two-requester arbiter that shares the core's single data-memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It sits between the IFU/LSU and the memory access block, which performs the DPI-backed pmem reads and writes. It supports one outstanding transaction at a time, uses valid/ready handshakes on every channel, and picks between simultaneous requesters round-robin.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MASK_W, 8, write byte-mask width (pmem write mask format)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ifu_req_valid / ifu_req_ready  in / out  1  IFU request handshake
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid / ifu_resp_ready  out / in  1  IFU response handshake
- ifu_rdata  out  DATA_W  fetched word
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_addr  in  ADDR_W  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  MASK_W  store byte mask
- lsu_resp_valid / lsu_resp_ready  out / in  1  LSU response handshake (loads and stores both get one)
- lsu_rdata  out  DATA_W  load data, raw word; the LSU applies sign/zero extension
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W/1/DATA_W/MASK_W  latched request fields
- mem_resp_valid / mem_resp_ready  in / out  1  memory response handshake
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If no requester is valid, stay in IDLE.
  - If exactly one is valid, grant it.
  - If both are valid, grant the one that was not granted last (`last_grant`).
  - The granted requester's req_ready = 1 (combinational on its valid, IDLE only). The other requester's req_ready = 0.
  - On grant, latch addr, wen, wdata and wmask (IFU grant: wen = 0, wdata = 0, wmask = 0) and record the owner. Next state is REQ.
- REQ:
  - mem_req_valid = 1, driven from the latched fields; the fields stay stable until accepted.
  - On mem_req_ready, next state is RESP.
- RESP:
  - mem_resp_ready = owner's resp_ready.
  - Owner's resp_valid = mem_resp_valid; owner's rdata = mem_rdata.
  - On the mem_resp_valid && owner resp_ready handshake: next state is IDLE and `last_grant` takes the owner's value.
- Non-owner outputs:
  - resp_valid = 0 at all times.
  - rdata = 0 (rdata is gated, not shared).
- Requests that arrive during REQ or RESP are not accepted (req_ready = 0). The requester keeps its valid high.
- Store responses: forwarded like loads; rdata is don't-care to the LSU but still passed through.

## Timing
- Reset values:
  - state = IDLE.
  - `last_grant` = LSU, so the IFU wins the first tie and boot fetch proceeds.
  - All handshake outputs and mem_wen = 0; latched fields = 0.
- Minimum latency, with memory ready immediately:
  - accept at cycle 0 (IDLE);
  - mem_req_valid at cycle 1;
  - mem_resp_valid earliest at cycle 2, with the owner's resp_valid in the same cycle.
  - Next accept is earliest at cycle 3, i.e. 3 cycles per transaction back-to-back.
- No combinational path from any mem_* input to any *_req_ready. Paths from mem_resp_* to owner resp_* are combinational by design.
- Reset asserted mid-transaction: the in-flight transaction is dropped and no response is delivered. The memory is required to be reset in the same cycle.
- mem_resp_valid arriving in IDLE or REQ is ignored: mem_resp_ready = 0.

## Structure
- Shared package `ysyx_24080014_pkg` holds:
  - state encoding IDLE=2'd0, REQ=2'd1, RESP=2'd2;
  - grant ids GNT_IFU=1'b0, GNT_LSU=1'b1.
- One sub-module `ysyx_24080014_rr_arb2`: combinational 2-way round-robin pick (inputs: two valids, last_grant; outputs: grant_valid, grant_id).
- FSM, field latches and response routing live in the top module.

## Test plan
- IFU only, addr 0x8000_0000, memory returns 0x0000_0413 on cycle 2 → ifu_req_ready at cycle 0, mem_addr = 0x8000_0000 with mem_wen = 0 at cycle 1, ifu_rdata = 0x0000_0413 at cycle 2, lsu_resp_valid stays 0.
- Both valid out of reset (IFU 0x8000_0000, LSU load 0x8000_0100) → IFU served first, LSU next. Sustained contention alternates IFU, LSU, IFU, LSU.
- LSU store addr 0x8000_0010, wdata 0xDEAD_BEEF, wmask 0x0F, memory stalls mem_req_ready for 3 cycles → mem_* fields held stable throughout, then one lsu_resp_valid pulse.
- Owner holds resp_ready = 0 for 4 cycles after mem_resp_valid → mem_resp_ready = 0 during the hold; the FSM stays in RESP and the new IFU request is not accepted until the handshake.
- rst asserted while in RESP → next cycle state is IDLE; all outputs are at reset values; the next tie goes to the IFU.
- Stray mem_resp_valid while IDLE → no resp_valid on either side, no state change.

Source files
------------

// File: rtl/ysyx_24080014_pkg.sv
// Shared types for the data-memory port arbiter.
// Holds the arbiter FSM state encoding and the requester grant ids.
package ysyx_24080014_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_IFU = 1'b0,
      GNT_LSU = 1'b1
   } grant_t;

endpackage

// File: rtl/ysyx_24080014_rr_arb2.sv
// Combinational 2-way round-robin pick between IFU and LSU.
// Ports: ifu_valid/lsu_valid in, last_grant in; grant_valid/grant_id out.
module ysyx_24080014_rr_arb2
   import ysyx_24080014_pkg::*;
(
   input  logic   ifu_valid,
   input  logic   lsu_valid,
   input  grant_t last_grant,
   output logic   grant_valid,
   output grant_t grant_id
);

   always_comb begin
      grant_valid = ifu_valid | lsu_valid;
      grant_id    = GNT_IFU;
      unique case (1'b1)
         ifu_valid & lsu_valid:
            // tie: whoever was not served last goes first
            grant_id = (last_grant == GNT_IFU) ? GNT_LSU : GNT_IFU;
         lsu_valid & ~ifu_valid:
            grant_id = GNT_LSU;
         default:
            grant_id = GNT_IFU;
      endcase
   end

endmodule

// File: rtl/ysyx_24080014_mem_arbiter.sv
// Shares the single data-memory port between IFU (read) and LSU (read/write).
// Ports: ifu_req/resp, lsu_req/resp, mem_req/resp valid/ready channels.
module ysyx_24080014_mem_arbiter
   import ysyx_24080014_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MASK_W = 8
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_resp_valid,
   input  logic              ifu_resp_ready,
   output logic [DATA_W-1:0] ifu_rdata,

   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic              lsu_wen,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [MASK_W-1:0] lsu_wmask,
   output logic              lsu_resp_valid,
   input  logic              lsu_resp_ready,
   output logic [DATA_W-1:0] lsu_rdata,

   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [MASK_W-1:0] mem_wmask,
   input  logic              mem_resp_valid,
   output logic              mem_resp_ready,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t        state, state_n;
   grant_t            last_grant;
   grant_t            owner;
   logic [ADDR_W-1:0] addr_q;
   logic              wen_q;
   logic [DATA_W-1:0] wdata_q;
   logic [MASK_W-1:0] wmask_q;

   logic   grant_valid;
   grant_t grant_id;
   logic   accept;
   logic   owner_rdy;
   logic   done;

   ysyx_24080014_rr_arb2 u_rr (
      .ifu_valid   (ifu_req_valid),
      .lsu_valid   (lsu_req_valid),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   // accept depends only on requester valids and own state
   assign accept    = (state == IDLE) & grant_valid;
   assign owner_rdy = (owner == GNT_LSU) ? lsu_resp_ready
                                         : ifu_resp_ready;
   assign done      = (state == RESP) & mem_resp_valid & owner_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (grant_valid)   state_n = REQ;
         REQ:  if (mem_req_ready) state_n = RESP;
         RESP: if (done)          state_n = IDLE;
         default:                 state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= GNT_LSU;
         owner      <= GNT_IFU;
         addr_q     <= '0;
         wen_q      <= 1'b0;
         wdata_q    <= '0;
         wmask_q    <= '0;
      end else begin
         if (accept) begin
            owner <= grant_id;
            if (grant_id == GNT_LSU) begin
               addr_q  <= lsu_addr;
               wen_q   <= lsu_wen;
               wdata_q <= lsu_wdata;
               wmask_q <= lsu_wmask;
            end else begin
               addr_q  <= ifu_addr;
               wen_q   <= 1'b0;
               wdata_q <= '0;
               wmask_q <= '0;
            end
         end
         if (done) begin
            last_grant <= owner;
         end
      end
   end

   always_comb begin
      ifu_req_ready  = accept & (grant_id == GNT_IFU);
      lsu_req_ready  = accept & (grant_id == GNT_LSU);

      mem_req_valid  = (state == REQ);
      mem_addr       = addr_q;
      mem_wen        = wen_q;
      mem_wdata      = wdata_q;
      mem_wmask      = wmask_q;

      mem_resp_ready = (state == RESP) & owner_rdy;

      // responses and read data are gated to the owner only
      ifu_resp_valid = 1'b0;
      ifu_rdata      = '0;
      lsu_resp_valid = 1'b0;
      lsu_rdata      = '0;
      if (state == RESP) begin
         if (owner == GNT_LSU) begin
            lsu_resp_valid = mem_resp_valid;
            lsu_rdata      = mem_rdata;
         end else begin
            ifu_resp_valid = mem_resp_valid;
            ifu_rdata      = mem_rdata;
         end
      end
   end

endmodule
